// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and response entry sizing shared by the ALU command responder.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // A response entry is {result, carry, zero}.
    function automatic int rsp_w(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous FIFO with async reset and occupancy count; overflow pushes and
// underflow pops are ignored.
module alu_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: accepts one ALU command at a time, executes it over EXEC_LAT cycles and
// queues {result, carry, zero} in a response FIFO drained over a valid/ready channel.
module alu_cmd_responder
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXEC_LAT  = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [2:0]       ctrl_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             busy_o
);
    localparam int EW = rsp_w(WIDTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             live_q;
    logic [EW-1:0]    last_q, head;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res;
    logic             carry, push, pop, accept;

    // live_q keeps the command channel closed until the first edge after reset.
    assign cmd_ready_o = live_q && (state_q == ST_IDLE) && (count < CW'(RSP_DEPTH));
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign busy_o      = state_q != ST_IDLE;
    assign rsp_valid_o = count != '0;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign {result_o, carry_o, zero_o} = rsp_valid_o ? head : last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            live_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                a_q  <= data0_i;
                b_q  <= data1_i;
                op_q <= ctrl_i;
            end
            if (pop) last_q <= head;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = accept ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'(EXEC_LAT - 1)) ? ST_WB : ST_EXEC;
            end
            ST_WB: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Carry/borrow come from the extra top bit of a WIDTH+1 add/subtract.
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        res   = (op_q == OP_ADD) ? sum[WIDTH-1:0] :
                (op_q == OP_SUB) ? diff[WIDTH-1:0] :
                (op_q == OP_AND) ? (a_q & b_q) :
                (op_q == OP_OR)  ? (a_q | b_q) :
                (op_q == OP_XOR) ? (a_q ^ b_q) :
                (op_q == OP_SHL) ? (a_q << b_q[2:0]) :
                (op_q == OP_SHR) ? (a_q >> b_q[2:0]) :
                                   {{(WIDTH-1){1'b0}}, a_q < b_q};
        carry = (op_q == OP_ADD) ? sum[WIDTH] :
                (op_q == OP_SUB) ? diff[WIDTH] : 1'b0;
    end

    alu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   ({res, carry, res == '0}),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb_alu_cmd_responder: directed commands with hand-computed responses; a scoreboard queue is
// filled on accept and drained by a monitor on every response handshake.
module tb_alu_cmd_responder;
    import alu_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i, cmd_valid_i, cmd_ready_o, rsp_valid_o, rsp_ready_i;
    logic [7:0] data0_i, data1_i, result_o;
    logic [2:0] ctrl_i;
    logic       carry_o, zero_o, busy_o;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;
    time        t0, t1, t2;

    alu_cmd_responder #(.WIDTH(8), .EXEC_LAT(1), .RSP_DEPTH(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .data0_i     (data0_i),
        .data1_i     (data1_i),
        .ctrl_i      (ctrl_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .carry_o     (carry_o),
        .zero_o      (zero_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] r, input logic c, input logic z);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        cmd_valid_i = 1'b1;
        data0_i     = a;
        data1_i     = b;
        ctrl_i      = op;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = cmd_ready_o;
            @(posedge clk_i);
            n++;
        end
        if (acc) exp_q.push_back({r, c, z});
        else chk("accept_timeout", 32'(acc), 32'd1);
        #1;
        cmd_valid_i = 1'b0;
        data0_i     = 8'hA5;
        data1_i     = 8'h5A;
        ctrl_i      = OP_SUB;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid_o) && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got r=%0h c=%0b z=%0b with nothing pending",
                         result_o, carry_o, zero_o);
            end else begin
                e = exp_q.pop_front();
                if ({result_o, carry_o, zero_o} !== e) begin
                    miscompares++;
                    $display("FAIL rsp: got r=%0h c=%0b z=%0b expected r=%0h c=%0b z=%0b",
                             result_o, carry_o, zero_o, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        data0_i     = '0;
        data1_i     = '0;
        ctrl_i      = '0;
        rsp_ready_i = 1'b1;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_outputs", {26'd0, rsp_valid_o, busy_o, result_o[3:0]} | 32'(result_o[7:4]) << 8
            | 32'(carry_o) << 12 | 32'(zero_o) << 13, 32'd0);
        #11 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

        // latency: response visible two edges after accept
        send(8'h06, 8'h02, OP_ADD, 8'h08, 1'b0, 1'b0);
        chk("busy_exec", 32'(busy_o), 32'd1);
        chk("lat_edge0", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("lat_edge1", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("lat_edge2", 32'(rsp_valid_o), 32'd1);
        chk("lat_result", 32'(result_o), 32'h08);

        send(8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1);
        send(8'h02, 8'h06, OP_SUB, 8'hFC, 1'b1, 1'b0);
        send(8'h06, 8'h02, OP_SUB, 8'h04, 1'b0, 1'b0);
        send(8'h05, 8'h05, OP_SUB, 8'h00, 1'b0, 1'b1);
        send(8'h81, 8'h01, OP_SHL, 8'h02, 1'b0, 1'b0);
        send(8'h80, 8'h07, OP_SHR, 8'h01, 1'b0, 1'b0);
        send(8'h02, 8'h06, OP_SLT, 8'h01, 1'b0, 1'b0);
        send(8'h06, 8'h02, OP_SLT, 8'h00, 1'b0, 1'b1);
        send(8'h06, 8'h02, OP_AND, 8'h02, 1'b0, 1'b0);
        drain();

        // backpressure: two fill the FIFO, the third stalls until a pop
        rsp_ready_i = 1'b0;
        send(8'h06, 8'h02, OP_OR, 8'h06, 1'b0, 1'b0);
        send(8'h06, 8'h02, OP_XOR, 8'h04, 1'b0, 1'b0);
        cmd_valid_i = 1'b1;
        data0_i     = 8'hFF;
        data1_i     = 8'h01;
        ctrl_i      = OP_ADD;
        repeat (6) @(posedge clk_i);
        #1;
        chk("bp_ready_low", 32'(cmd_ready_o), 32'd0);
        chk("bp_valid", 32'(rsp_valid_o), 32'd1);
        chk("bp_head", 32'(result_o), 32'h06);
        repeat (3) @(posedge clk_i);
        #1;
        chk("bp_head_stable", 32'(result_o), 32'h06);
        chk("bp_busy", 32'(busy_o), 32'd0);
        rsp_ready_i = 1'b1;
        send(8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1);
        drain();
        chk("hold_last", 32'({result_o, carry_o, zero_o}), 32'({8'h00, 1'b1, 1'b1}));

        // throughput: one accept every EXEC_LAT+2 cycles
        send(8'h10, 8'h20, OP_ADD, 8'h30, 1'b0, 1'b0);
        t0 = $time;
        send(8'h30, 8'h0F, OP_XOR, 8'h3F, 1'b0, 1'b0);
        t1 = $time;
        send(8'h0F, 8'h30, OP_OR, 8'h3F, 1'b0, 1'b0);
        t2 = $time;
        chk("tput_1", 32'(t1 - t0), 32'd30);
        chk("tput_2", 32'(t2 - t1), 32'd30);
        drain();

        // simultaneous push and pop keep one entry queued
        rsp_ready_i = 1'b0;
        send(8'h06, 8'h02, OP_SUB, 8'h04, 1'b0, 1'b0);
        send(8'h81, 8'h01, OP_SHL, 8'h02, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        chk("pp_valid", 32'(rsp_valid_o), 32'd1);
        chk("pp_head", 32'(result_o), 32'h02);
        chk("pp_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        chk("pp_still_one", 32'(rsp_valid_o), 32'd1);
        rsp_ready_i = 1'b1;
        drain();

        // reset during EXEC with one entry queued
        rsp_ready_i = 1'b0;
        send(8'h06, 8'h02, OP_SUB, 8'h04, 1'b0, 1'b0);
        send(8'h33, 8'h11, OP_ADD, 8'h44, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
        chk("pre_rst_head", 32'(result_o), 32'h04);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_result", 32'(result_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready_o), 32'd0);
        exp_q.delete();
        #20 rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("no_stale", 32'(rsp_valid_o), 32'd0);
        send(8'h02, 8'h06, OP_SLT, 8'h01, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
